// File: rtl/pong_video_out_if.sv
// Game-state and video signals between the game logic and the display stage.
// The game drives the master side; pong_video_out sits on the slave side.
interface pong_video_out_if;
  logic [9:0] pad_left;
  logic [9:0] pad_right;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;
  logic       frame_start;

  modport master (
    output pad_left, pad_right, ball_x, ball_y,
    input  hsync, vsync, rgb, frame_start
  );

  modport slave (
    input  pad_left, pad_right, ball_x, ball_y,
    output hsync, vsync, rgb, frame_start
  );
endinterface

// File: rtl/pong_video_out.sv
// VGA display stage: pixel-rate timing, per-frame game-state snapshot and
// colour generation for pads, ball and centre net.
module pong_video_out #(
  parameter int CLK_DIV       = 2,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PAD_WIDTH     = 8,
  parameter int PAD_HEIGHT    = 64,
  parameter int PAD_DISTANCE  = 16,
  parameter int BALL_R        = 3,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33
) (
  input logic             clk,
  input logic             rst,
  pong_video_out_if.slave video
);

  localparam int H_TOTAL = SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(SCREEN_WIDTH);
  localparam logic [9:0] V_VIS    = 10'(SCREEN_HEIGHT);
  localparam logic [9:0] HS_START = 10'(SCREEN_WIDTH + H_FRONT);
  localparam logic [9:0] HS_STOP  = 10'(SCREEN_WIDTH + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(SCREEN_HEIGHT + V_FRONT);
  localparam logic [9:0] VS_STOP  = 10'(SCREEN_HEIGHT + V_FRONT + V_SYNC);
  localparam logic [9:0] NET_X0   = 10'(SCREEN_WIDTH / 2 - 1);
  localparam logic [9:0] NET_X1   = 10'(SCREEN_WIDTH / 2);
  localparam logic [9:0] CENTRE_X = 10'(SCREEN_WIDTH / 2);
  localparam logic [9:0] CENTRE_Y = 10'(SCREEN_HEIGHT / 2);
  localparam logic [8:0] CENTRE_B = 9'(SCREEN_HEIGHT / 2);

  typedef logic signed [11:0] coord_t;

  localparam coord_t LPAD_X0    = coord_t'(PAD_DISTANCE);
  localparam coord_t LPAD_X1    = coord_t'(PAD_DISTANCE + PAD_WIDTH);
  localparam coord_t RPAD_X0    = coord_t'(SCREEN_WIDTH - PAD_DISTANCE - PAD_WIDTH);
  localparam coord_t RPAD_X1    = coord_t'(SCREEN_WIDTH - PAD_DISTANCE);
  localparam coord_t PAD_HALF   = coord_t'(PAD_HEIGHT / 2);
  localparam coord_t BALL_REACH = coord_t'(BALL_R);

  logic [DIV_W-1:0] div;
  logic             pix_en;
  logic [9:0]       hc;
  logic [9:0]       vc;
  logic             snap_point;

  logic [9:0] snap_pad_left;
  logic [9:0] snap_pad_right;
  logic [9:0] snap_ball_x;
  logic [8:0] snap_ball_y;

  logic       hsync_q;
  logic       vsync_q;
  logic [2:0] rgb_q;
  logic       frame_start_q;

  always_comb begin
    pix_en     = (div == DIV_LAST);
    snap_point = (hc == 10'd0) && (vc == V_VIS);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div <= '0;
    end else if (pix_en) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hc <= 10'd0;
      vc <= 10'd0;
    end else if (pix_en) begin
      if (hc == H_LAST) begin
        hc <= 10'd0;
        vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // The snapshot is taken just after the last visible line so a whole frame
  // is always drawn from one consistent set of game coordinates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_pad_left  <= CENTRE_Y;
      snap_pad_right <= CENTRE_Y;
      snap_ball_x    <= CENTRE_X;
      snap_ball_y    <= CENTRE_B;
    end else if (pix_en && snap_point) begin
      snap_pad_left  <= video.pad_left;
      snap_pad_right <= video.pad_right;
      snap_ball_x    <= video.ball_x;
      snap_ball_y    <= video.ball_y;
    end
  end

  coord_t     x;
  coord_t     y;
  coord_t     left_c;
  coord_t     right_c;
  coord_t     bx;
  coord_t     by;
  logic       visible;
  logic       left_hit;
  logic       right_hit;
  logic       ball_hit;
  logic       net_hit;
  logic [2:0] colour;
  logic       hsync_next;
  logic       vsync_next;

  // Signed 12-bit geometry lets pad and ball extents run past the top/left
  // edge without wrapping around to the far side of the screen.
  always_comb begin
    x       = coord_t'({2'b00, hc});
    y       = coord_t'({2'b00, vc});
    left_c  = coord_t'({2'b00, snap_pad_left});
    right_c = coord_t'({2'b00, snap_pad_right});
    bx      = coord_t'({2'b00, snap_ball_x});
    by      = coord_t'({3'b000, snap_ball_y});

    visible   = (hc < H_VIS) && (vc < V_VIS);
    left_hit  = (x >= LPAD_X0) && (x < LPAD_X1) &&
                (y >= left_c - PAD_HALF) && (y <= left_c + PAD_HALF);
    right_hit = (x >= RPAD_X0) && (x < RPAD_X1) &&
                (y >= right_c - PAD_HALF) && (y <= right_c + PAD_HALF);
    ball_hit  = (x >= bx - BALL_REACH) && (x <= bx + BALL_REACH) &&
                (y >= by - BALL_REACH) && (y <= by + BALL_REACH);
    net_hit   = ((hc == NET_X0) || (hc == NET_X1)) && !vc[3];

    colour = 3'b000;
    if (visible) begin
      if (ball_hit) begin
        colour = 3'b110;
      end else if (left_hit || right_hit) begin
        colour = 3'b111;
      end else if (net_hit) begin
        colour = 3'b001;
      end
    end

    hsync_next = !((hc >= HS_START) && (hc < HS_STOP));
    vsync_next = !((vc >= VS_START) && (vc < VS_STOP));
  end

  // Sync and colour share one register stage so they stay aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 3'b000;
    end else if (pix_en) begin
      hsync_q <= hsync_next;
      vsync_q <= vsync_next;
      rgb_q   <= colour;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= pix_en && snap_point;
    end
  end

  assign video.hsync       = hsync_q;
  assign video.vsync       = vsync_q;
  assign video.rgb         = rgb_q;
  assign video.frame_start = frame_start_q;

endmodule

// File: tb/tb_pong_video_out.sv
// Self-checking bench for pong_video_out on a reduced screen geometry, compared
// pixel by pixel against a coordinate-level model of the display rules.
module tb_pong_video_out;

  localparam int CLK_DIV = 2;
  localparam int SW = 64;
  localparam int SH = 32;
  localparam int PW = 2;
  localparam int PH = 8;
  localparam int PD = 4;
  localparam int BR = 1;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int VF = 3;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = SW + HF + HS + HB;
  localparam int VT = SH + VF + VS + VB;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pong_video_out_if vif ();

  pong_video_out #(
    .CLK_DIV(CLK_DIV), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH),
    .PAD_WIDTH(PW), .PAD_HEIGHT(PH), .PAD_DISTANCE(PD), .BALL_R(BR),
    .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .video(vif)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int pos_h, pos_v;
  int snap_pl, snap_pr, snap_bx, snap_by;
  logic exp_hs, exp_vs, exp_fs;
  logic [2:0] exp_rgb;
  logic [2:0] obs [SH][SW];

  int pos_cnt = 0;
  int t_rel = 0;
  int last_hfall = 0, hlow = 0, hperiod = 0;
  int last_vfall = 0, vlow = 0;
  int last_fs = 0, fs_period = 0, fs_count = 0;
  logic prev_hs = 1'b1, prev_vs = 1'b1;

  always @(posedge clk) pos_cnt++;

  // Edge timing is measured in system clocks, sampled mid-cycle.
  always @(negedge clk) begin
    if (prev_hs && vif.hsync === 1'b0) begin
      hperiod = pos_cnt - last_hfall;
      last_hfall = pos_cnt;
    end
    if (!prev_hs && vif.hsync === 1'b1) hlow = pos_cnt - last_hfall;
    if (prev_vs && vif.vsync === 1'b0) last_vfall = pos_cnt;
    if (!prev_vs && vif.vsync === 1'b1) vlow = pos_cnt - last_vfall;
    if (vif.frame_start === 1'b1) begin
      fs_period = pos_cnt - last_fs;
      last_fs = pos_cnt;
      fs_count++;
    end
    prev_hs = (vif.hsync !== 1'b0);
    prev_vs = (vif.vsync !== 1'b0);
  end

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic logic [2:0] ref_colour(input int px, input int py);
    if (px >= SW || py >= SH) return 3'b000;
    if (iabs(px - snap_bx) <= BR && iabs(py - snap_by) <= BR) return 3'b110;
    if (px >= PD && px < PD + PW && iabs(py - snap_pl) <= PH / 2) return 3'b111;
    if (px >= SW - PD - PW && px < SW - PD && iabs(py - snap_pr) <= PH / 2) return 3'b111;
    if ((px == SW / 2 - 1 || px == SW / 2) && ((py / 8) % 2 == 0)) return 3'b001;
    return 3'b000;
  endfunction

  task automatic model_reset();
    pos_h = 0;
    pos_v = 0;
    snap_pl = SH / 2;
    snap_pr = SH / 2;
    snap_bx = SW / 2;
    snap_by = SH / 2;
    exp_hs = 1'b1;
    exp_vs = 1'b1;
    exp_rgb = 3'b000;
    exp_fs = 1'b0;
  endtask

  task automatic step_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < CLK_DIV - 1; k++) begin
        @(posedge clk); #1;
        vectors++;
        if ({vif.hsync, vif.vsync, vif.rgb, vif.frame_start} !== {exp_hs, exp_vs, exp_rgb, 1'b0}) begin
          miscompares++;
          $display("[TB] FAIL hold h=%0d v=%0d: got hs=%b vs=%b rgb=%b fs=%b, required hs=%b vs=%b rgb=%b fs=0",
                   pos_h, pos_v, vif.hsync, vif.vsync, vif.rgb, vif.frame_start, exp_hs, exp_vs, exp_rgb);
        end
      end
      @(posedge clk); #1;
      exp_hs = !(pos_h >= SW + HF && pos_h < SW + HF + HS);
      exp_vs = !(pos_v >= SH + VF && pos_v < SH + VF + VS);
      exp_rgb = ref_colour(pos_h, pos_v);
      exp_fs = (pos_h == 0 && pos_v == SH);
      if (exp_fs) begin
        snap_pl = int'(vif.pad_left);
        snap_pr = int'(vif.pad_right);
        snap_bx = int'(vif.ball_x);
        snap_by = int'(vif.ball_y);
      end
      vectors++;
      if ({vif.hsync, vif.vsync, vif.rgb, vif.frame_start} !== {exp_hs, exp_vs, exp_rgb, exp_fs}) begin
        miscompares++;
        $display("[TB] FAIL pixel h=%0d v=%0d: got hs=%b vs=%b rgb=%b fs=%b, required hs=%b vs=%b rgb=%b fs=%b",
                 pos_h, pos_v, vif.hsync, vif.vsync, vif.rgb, vif.frame_start, exp_hs, exp_vs, exp_rgb, exp_fs);
      end
      if (pos_h < SW && pos_v < SH) obs[pos_v][pos_h] = vif.rgb;
      pos_h++;
      if (pos_h == HT) begin
        pos_h = 0;
        pos_v = (pos_v == VT - 1) ? 0 : pos_v + 1;
      end
    end
  endtask

  task automatic run_to(input int h, input int v);
    int guard = 0;
    while (!(pos_h == h && pos_v == v) && guard <= HT * VT) begin
      step_pixels(1);
      guard++;
    end
  endtask

  task automatic do_reset(input int pre_clks, input int cycles);
    repeat (pre_clks) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      vectors++;
      if ({vif.hsync, vif.vsync, vif.rgb, vif.frame_start} !== 6'b11_000_0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs cycle %0d: got hs=%b vs=%b rgb=%b fs=%b, required 1 1 000 0",
                 c, vif.hsync, vif.vsync, vif.rgb, vif.frame_start);
      end
    end
    rst = 1'b1;
    t_rel = pos_cnt;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(0, 5);
    step_pixels(SW + HF + 1);
    @(negedge clk); #1;
    vectors++;
    if (last_hfall - t_rel !== CLK_DIV * (SW + HF + 1)) begin
      miscompares++;
      $display("[TB] FAIL first_hfall: got %0d clk, required %0d", last_hfall - t_rel, CLK_DIV * (SW + HF + 1));
    end
    step_pixels(HT);
    @(negedge clk); #1;
    vectors++;
    if (hlow !== CLK_DIV * HS) begin
      miscompares++;
      $display("[TB] FAIL hsync_low: got %0d clk, required %0d", hlow, CLK_DIV * HS);
    end
    vectors++;
    if (hperiod !== CLK_DIV * HT) begin
      miscompares++;
      $display("[TB] FAIL line_period: got %0d clk, required %0d", hperiod, CLK_DIV * HT);
    end
  endtask

  task automatic test_vertical();
    int fs_before;
    fs_before = fs_count;
    step_pixels(2 * HT * VT);
    @(negedge clk); #1;
    vectors++;
    if (fs_count - fs_before !== 2) begin
      miscompares++;
      $display("[TB] FAIL frame_start_count: got %0d, required 2", fs_count - fs_before);
    end
    vectors++;
    if (fs_period !== CLK_DIV * HT * VT) begin
      miscompares++;
      $display("[TB] FAIL frame_period: got %0d clk, required %0d", fs_period, CLK_DIV * HT * VT);
    end
    vectors++;
    if (vlow !== CLK_DIV * VS * HT) begin
      miscompares++;
      $display("[TB] FAIL vsync_low: got %0d clk, required %0d", vlow, CLK_DIV * VS * HT);
    end
    vectors++;
    if (last_vfall - t_rel !== CLK_DIV * (HT * VT + (SH + VF) * HT + 1)) begin
      miscompares++;
      $display("[TB] FAIL vsync_fall: got %0d clk, required %0d",
               last_vfall - t_rel, CLK_DIV * (HT * VT + (SH + VF) * HT + 1));
    end
  endtask

  task automatic test_pad_render();
    run_to(0, SH);
    vif.pad_left = 10'(SH / 2);
    vif.pad_right = 10'd25;
    vif.ball_x = 10'd40;
    vif.ball_y = 9'd28;
    step_pixels(1);
    run_to(0, SH);
    for (int px = PD; px < PD + PW; px++) begin
      vectors++;
      if (obs[SH / 2 - PH / 2][px] !== 3'b111) begin
        miscompares++;
        $display("[TB] FAIL pad_top x=%0d: got %b, required 111", px, obs[SH / 2 - PH / 2][px]);
      end
    end
    vectors++;
    if (obs[SH / 2 - PH / 2 - 1][PD] !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL pad_above: got %b, required 000", obs[SH / 2 - PH / 2 - 1][PD]);
    end
    vectors++;
    if (obs[SH / 2][PD + PW] !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL pad_right_of: got %b, required 000", obs[SH / 2][PD + PW]);
    end
    vectors++;
    if (obs[SH / 2 + PH / 2][PD + 1] !== 3'b111 || obs[SH / 2 + PH / 2 + 1][PD + 1] !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL pad_bottom: got %b/%b, required 111/000",
               obs[SH / 2 + PH / 2][PD + 1], obs[SH / 2 + PH / 2 + 1][PD + 1]);
    end
    vectors++;
    if (obs[25][SW - PD - PW] !== 3'b111 || obs[29][SW - PD - 1] !== 3'b111 ||
        obs[30][SW - PD - 1] !== 3'b000 || obs[25][SW - PD - PW - 1] !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL right_pad: got %b %b %b %b, required 111 111 000 000",
               obs[25][SW - PD - PW], obs[29][SW - PD - 1], obs[30][SW - PD - 1], obs[25][SW - PD - PW - 1]);
    end
  endtask

  task automatic test_edge_underflow();
    int bad_bottom, bad_right;
    run_to(0, SH);
    vif.pad_left = 10'(SH / 2);
    vif.pad_right = 10'd2;
    vif.ball_x = 10'd0;
    vif.ball_y = 9'd0;
    step_pixels(1);
    run_to(0, SH);
    for (int row = 0; row <= 2 + PH / 2; row++) begin
      vectors++;
      if (obs[row][SW - PD - PW] !== 3'b111 || obs[row][SW - PD - 1] !== 3'b111) begin
        miscompares++;
        $display("[TB] FAIL underflow_pad row=%0d: got %b %b, required 111 111",
                 row, obs[row][SW - PD - PW], obs[row][SW - PD - 1]);
      end
    end
    vectors++;
    if (obs[3 + PH / 2][SW - PD - PW] !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL underflow_pad_end: got %b, required 000", obs[3 + PH / 2][SW - PD - PW]);
    end
    for (int row = 0; row <= BR; row++) begin
      for (int col = 0; col <= BR; col++) begin
        vectors++;
        if (obs[row][col] !== 3'b110) begin
          miscompares++;
          $display("[TB] FAIL underflow_ball x=%0d y=%0d: got %b, required 110", col, row, obs[row][col]);
        end
      end
    end
    vectors++;
    if (obs[0][BR + 1] !== 3'b000 || obs[BR + 1][0] !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL underflow_ball_edge: got %b %b, required 000 000", obs[0][BR + 1], obs[BR + 1][0]);
    end
    bad_bottom = 0;
    bad_right = 0;
    for (int col = 0; col < SW; col++)
      if (obs[SH - 1][col] === 3'b111 || obs[SH - 1][col] === 3'b110) bad_bottom++;
    for (int row = 0; row < SH; row++)
      if (obs[row][SW - 1] === 3'b111 || obs[row][SW - 1] === 3'b110) bad_right++;
    vectors++;
    if (bad_bottom !== 0 || bad_right !== 0) begin
      miscompares++;
      $display("[TB] FAIL wraparound: got %0d bottom and %0d right lit pixels, required 0 and 0", bad_bottom, bad_right);
    end
  endtask

  task automatic test_snapshot_isolation();
    run_to(0, SH);
    vif.pad_left = 10'(SH / 2);
    vif.pad_right = 10'(SH / 2);
    vif.ball_x = 10'(SW / 2);
    vif.ball_y = 9'(SH / 2);
    step_pixels(1);
    run_to(0, 10);
    vif.ball_x = 10'd10;
    run_to(0, SH);
    vectors++;
    if (obs[SH / 2][SW / 2] !== 3'b110 || obs[SH / 2][10] !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL isolation_same_frame: got %b at x32, %b at x10, required 110 and 000",
               obs[SH / 2][SW / 2], obs[SH / 2][10]);
    end
    step_pixels(1);
    run_to(0, SH);
    vectors++;
    if (obs[SH / 2][10] !== 3'b110 || obs[SH / 2][SW / 2] !== 3'b001 || obs[SH / 2][SW / 2 + 1] !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL isolation_next_frame: got %b %b %b, required 110 001 000",
               obs[SH / 2][10], obs[SH / 2][SW / 2], obs[SH / 2][SW / 2 + 1]);
    end
  endtask

  task automatic test_random_frames();
    int bx, by, xl, xh, yl, yh, want, got;
    for (int f = 0; f < 2; f++) begin
      run_to(0, SH);
      vif.pad_left = 10'($urandom_range(0, SH + PH));
      vif.pad_right = 10'($urandom_range(0, SH + PH));
      vif.ball_x = ($urandom_range(0, 3) == 0) ? 10'($urandom()) : 10'($urandom_range(0, SW + BR + 1));
      vif.ball_y = 9'($urandom_range(0, SH + BR + 1));
      bx = int'(vif.ball_x);
      by = int'(vif.ball_y);
      step_pixels(1);
      run_to(0, $urandom_range(1, SH - 1));
      vif.pad_left = 10'($urandom());
      vif.pad_right = 10'($urandom());
      vif.ball_x = 10'($urandom_range(0, SW - 1));
      vif.ball_y = 9'($urandom_range(0, SH - 1));
      run_to(0, SH);
      xl = (bx - BR < 0) ? 0 : bx - BR;
      xh = (bx + BR > SW - 1) ? SW - 1 : bx + BR;
      yl = (by - BR < 0) ? 0 : by - BR;
      yh = (by + BR > SH - 1) ? SH - 1 : by + BR;
      want = ((xh >= xl) ? xh - xl + 1 : 0) * ((yh >= yl) ? yh - yl + 1 : 0);
      got = 0;
      for (int row = 0; row < SH; row++)
        for (int col = 0; col < SW; col++)
          if (obs[row][col] === 3'b110) got++;
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL ball_area frame %0d bx=%0d by=%0d: got %0d yellow pixels, required %0d",
                 f, bx, by, got, want);
      end
    end
  endtask

  task automatic test_mid_reset();
    run_to(SW / 2, 20);
    vif.ball_x = 10'd5;
    vif.ball_y = 9'd5;
    vif.pad_left = 10'd3;
    vif.pad_right = 10'd30;
    do_reset(1, 1);
    step_pixels(SW + HF + 1);
    @(negedge clk); #1;
    vectors++;
    if (last_hfall - t_rel !== CLK_DIV * (SW + HF + 1)) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_hfall: got %0d clk, required %0d", last_hfall - t_rel, CLK_DIV * (SW + HF + 1));
    end
    run_to(0, SH / 2 + PH / 2 + 1);
    vectors++;
    if (obs[SH / 2][SW / 2] !== 3'b110 || obs[SH / 2][SW / 2 - BR - 1] !== 3'b000 ||
        obs[SH / 2][PD] !== 3'b111 || obs[SH / 2][SW - PD - 1] !== 3'b111) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_snapshot: got %b %b %b %b, required 110 000 111 111",
               obs[SH / 2][SW / 2], obs[SH / 2][SW / 2 - BR - 1], obs[SH / 2][PD], obs[SH / 2][SW - PD - 1]);
    end
  endtask

  initial begin
    vif.pad_left = 10'd10;
    vif.pad_right = 10'd20;
    vif.ball_x = 10'd40;
    vif.ball_y = 9'd5;
    model_reset();
    test_reset();
    test_vertical();
    test_pad_render();
    test_edge_underflow();
    test_snapshot_isolation();
    test_random_frames();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pong_video_out.md
# pong_video_out

Downstream display stage of the game. It consumes the game state (pad centres, ball position) and drives a 640x480@60 VGA port: sync timing, a per-frame state snapshot and pixel colour generation. It runs on the system clock and derives the pixel rate internally with a clock enable.

## Interface
Parameters:
- CLK_DIV, 2: system clocks per pixel; pixel enable `pix_en` is high once every CLK_DIV cycles.
- SCREEN_WIDTH, 640: visible width in pixels; equals the H visible count.
- SCREEN_HEIGHT, 480: visible height in lines; equals the V visible count.
- PAD_WIDTH, 8: pad width in pixels.
- PAD_HEIGHT, 64: pad height in pixels, centred on the pad coordinate.
- PAD_DISTANCE, 16: gap in pixels between a screen edge and the outer face of its pad.
- BALL_R, 3: ball half-size in pixels; the ball is a square of side 2*BALL_R+1.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous reset, active-low.
- pad_left, in, 10: y coordinate of the left pad centre.
- pad_right, in, 10: y coordinate of the right pad centre.
- ball_x, in, 10: x coordinate of the ball centre.
- ball_y, in, 9: y coordinate of the ball centre.
- hsync, out, 1: horizontal sync, active-low.
- vsync, out, 1: vertical sync, active-low.
- rgb, out, 3: {R,G,B}, one bit per channel.
- frame_start, out, 1: one-clk pulse when the snapshot is taken.

## Operation
- **Pixel enable:** divider counter runs 0..CLK_DIV-1. `pix_en` is high when the counter = CLK_DIV-1. All state below advances only on clk cycles where `pix_en` is high.
- **Horizontal counter `hc`:** 0..799, wraps to 0.
  - Visible range 0..639.
  - Front porch 640..655.
  - Sync 656..751.
  - Back porch 752..799.
- **Vertical counter `vc`:** 0..524. It increments when `hc` wraps and wraps to 0 after 524.
  - Visible range 0..479.
  - Front porch 480..489.
  - Sync 490..491.
  - Back porch 492..524.
- **Snapshot:** on the pix_en cycle where `hc`=0 and `vc`=480, latch all four game inputs into internal registers and pulse `frame_start` for one clk. Drawing uses only the snapshot, so input changes mid-frame never cause tearing.
- **Drawing:** all comparisons are 12-bit signed, computed from zero-extended operands, so `pad - PAD_HEIGHT/2` and `ball - BALL_R` may go negative without wrapping. Colour for the pixel at (hc, vc):
  - Outside the visible area: 000.
  - Left pad: PAD_DISTANCE <= hc < PAD_DISTANCE+PAD_WIDTH and |vc - padL| <= PAD_HEIGHT/2 → 111.
  - Right pad: SCREEN_WIDTH-PAD_DISTANCE-PAD_WIDTH <= hc < SCREEN_WIDTH-PAD_DISTANCE, same vertical rule with padR → 111.
  - Ball: |hc - bx| <= BALL_R and |vc - by| <= BALL_R → 110 (yellow). The ball has priority over the pads.
  - Centre net: hc ∈ {319,320} and vc[3]=0 → 001. Lowest priority above background.
  - Otherwise: 000.
  - Parts of the ball or pads that fall outside 0..639 / 0..479 are simply not shown.
- **Reset (rst=0 at a clk edge):**
  - Divider, `hc`, `vc` ← 0.
  - hsync, vsync ← 1; rgb ← 000; frame_start ← 0.
  - Snapshot ← padL=padR=240, bx=320, by=240.
  - Reset asserted mid-frame has the same effect; the first line after release starts at `hc`=0, `vc`=0.

## Timing
- **Output pipeline:** hsync, vsync and rgb are registered. They reflect counter values (hc, vc) one pixel period after those values are present, so sync and colour stay mutually aligned.
- Outputs change only on pix_en cycles. frame_start is the only exception: it is high for exactly one clk.
- **Periods** (CLK_DIV=2):
  - Line: 1600 clk.
  - Frame: 525*1600 = 840000 clk.
  - hsync low: 96 pixel periods per line.
  - vsync low: 2 lines per frame.
- **Snapshot visibility:** a value captured at `vc`=480 is first drawn on line 0 of the next frame. Input changes at any other time have no effect until the next capture.
- **Latency:** rgb reflecting a new input appears at most 1 frame + 45 lines + 1 pixel after the input changes.

## Test plan
- **Reset and sync timing:** hold rst=0 for 5 clk, then release.
  - Outputs during reset: hsync=vsync=1, rgb=000.
  - First hsync falling edge occurs 657 pixel periods (1314 clk) after release.
  - hsync stays low 192 clk; line period is 1600 clk.
- **Vertical timing:** run 2 frames.
  - vsync is low for 3200 clk starting at line 490 + 1 pixel.
  - frame_start pulses once per 840000 clk.
- **Pad rendering:** pad_left=240 before snapshot.
  - Line 208, pixels 16..23 → rgb=111.
  - Line 207, pixel 16 → 000.
  - Line 240, pixel 24 → 000.
- **Edge underflow:** pad_right=5, ball_x=1, ball_y=0.
  - Right pad: rows 0..37 are white at x 616..623.
  - Ball: pixels x 0..4, y 0..3 are 110.
  - No white or yellow appears at the bottom or right edge (no wraparound).
- **Snapshot isolation:** change ball_x from 320 to 100 at line 100.
  - The rest of the frame still draws the ball at 320.
  - The next frame draws it at 100.
- **Mid-frame reset:** assert rst=0 for 1 clk at line 300.
  - Outputs return to reset values.
  - Snapshot returns to the centre values.
  - The next hsync falls 1314 clk after release.
